// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths, memory depth, the
// memory-unit state encoding and the wait-state limits.
package cpu_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int MEM_DEPTH  = 2 ** ADDR_W_DEF;

    // Wait-state counter: WAIT_CYCLES may range 0..WAIT_MAX.
    localparam int WAIT_MAX = 15;
    localparam int WAIT_W   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        LOAD   = 2'd3
    } memState_t;

endpackage

// File: rtl/mem_array.sv
// Single-port word storage with synchronous write and a registered read.
// Ports:
//   clk, reset : clock; synchronous active-high reset (clears rdata only)
//   we, re     : write / read strobes for this cycle
//   addr       : word address
//   wdata      : write data
//   rdata      : read register; changes only when re is high, else holds
module mem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    // Storage is deliberately not reset so boot-loaded contents survive.
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_unit.sv
// Program/data memory for the CPU datapath with programmable wait states,
// a ready/busy handshake and a sequential boot-load port.
// Ports:
//   clk, reset          : clock; synchronous active-high reset
//   read, write         : level access requests, sampled only in IDLE
//   addr, wdata         : access address (AR) and write data (DR)
//   rdata               : registered read data, held until the next read
//   ready               : one-cycle pulse when an access has committed
//   busy                : high during ACCESS, RESP and LOAD
//   load_en             : boot-load mode request (level)
//   load_valid, load_data : boot byte stream, written at an incrementing pointer
//   load_done           : sticky load-complete flag
//   dbgState            : current FSM state encoding (memState_t)
//
// Handshake: a request (read or write held high) is accepted on the edge it
// is seen in IDLE; ready pulses for exactly one cycle once the access has
// committed, and the requester must drop read/write in that ready cycle,
// otherwise the still-high level is taken as a fresh request.
module mem_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    input  logic              load_en,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_done,
    output logic [1:0]        dbgState
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    memState_t         state, stateNext;
    logic [WAIT_W-1:0] waitCnt;
    logic [ADDR_W-1:0] loadPtr;
    logic [ADDR_W-1:0] latAddr;
    logic [DATA_W-1:0] latData;
    logic              latWrite;
    logic              loadDoneReg;

    logic              memWe, memRe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic; load_en has priority over write, write over read.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (load_en) begin
                    stateNext = LOAD;
                end else if (write || read) begin
                    stateNext = ACCESS;
                end
            end
            ACCESS: begin
                if (waitCnt == '0) begin
                    stateNext = RESP;
                end
            end
            RESP: stateNext = IDLE;
            LOAD: begin
                // Dropping load_en wins over a simultaneous load_valid.
                if (!load_en) begin
                    stateNext = IDLE;
                end else if (load_valid && (loadPtr == LAST_ADDR)) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        ready = (state == RESP);
        busy  = (state != IDLE);
    end

    assign load_done = loadDoneReg;
    assign dbgState  = state;

    // Request latches, wait counter, load pointer and done flag
    always_ff @(posedge clk) begin
        if (reset) begin
            waitCnt     <= '0;
            loadPtr     <= '0;
            latAddr     <= '0;
            latData     <= '0;
            latWrite    <= 1'b0;
            loadDoneReg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_en) begin
                        loadPtr     <= '0;
                        loadDoneReg <= 1'b0;
                    end else if (write || read) begin
                        latAddr  <= addr;
                        latData  <= wdata;
                        latWrite <= write;
                        waitCnt  <= WAIT_W'(WAIT_CYCLES);
                    end
                end
                ACCESS: begin
                    if (waitCnt != '0) begin
                        waitCnt <= waitCnt - 1'b1;
                    end
                end
                LOAD: begin
                    if (!load_en) begin
                        loadDoneReg <= 1'b1;
                    end else if (load_valid) begin
                        // The pointer stops at the last word instead of wrapping.
                        if (loadPtr == LAST_ADDR) begin
                            loadDoneReg <= 1'b1;
                        end else begin
                            loadPtr <= loadPtr + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Port mux into the array. Strobes are gated with reset so that an access
    // or load cut short by reset never commits on the reset edge.
    always_comb begin
        memWe    = 1'b0;
        memRe    = 1'b0;
        memAddr  = latAddr;
        memWdata = latData;
        if (state == LOAD) begin
            memAddr  = loadPtr;
            memWdata = load_data;
            memWe    = load_en && load_valid && !reset;
        end else if (state == ACCESS && waitCnt == '0) begin
            memWe = latWrite && !reset;
            memRe = !latWrite && !reset;
        end
    end

    mem_array #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) uArray (
        .clk  (clk),
        .reset(reset),
        .we   (memWe),
        .re   (memRe),
        .addr (memAddr),
        .wdata(memWdata),
        .rdata(rdata)
    );

endmodule

// File: doc/mem_unit.md
Name: mem_unit

Overview:
- Word-addressed program/data memory sitting directly downstream of the CPU datapath.
- Consumes the datapath's read/write strobes, the AR address and the DR write data; returns read data to the DR bus source.
- Adds programmable wait states and a ready/busy handshake for the controller FSM.
- Provides a boot-load port that fills memory sequentially while the CPU is held idle.

Parameters:
ADDR_W, 8, address width; depth = 2**ADDR_W words.
DATA_W, 8, word width; matches the IR/DR width.
WAIT_CYCLES, 2, extra access cycles inserted before commit; legal range 0..15.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
read  input  1  read request from the datapath (level).
write  input  1  write request from the datapath (level).
addr  input  ADDR_W  access address (AR).
wdata  input  DATA_W  write data (DR).
rdata  output  DATA_W  registered read data; holds its value until the next read commits.
ready  output  1  one-cycle pulse: access committed.
busy  output  1  high while an access or load is in progress.
load_en  input  1  boot-load mode request (level).
load_valid  input  1  load_data is valid this cycle.
load_data  input  DATA_W  boot byte.
load_done  output  1  sticky load-complete flag.

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high.
- Reset values:
  - state=IDLE; rdata=0; ready=0; busy=0; load_done=0; load pointer=0; wait counter=0.
  - Memory contents are NOT cleared.
- FSM states: IDLE, ACCESS, RESP, LOAD.
- IDLE:
  - Priority order: load_en > write > read.
  - load_en=1 -> LOAD; pointer cleared to 0; load_done cleared to 0.
  - Else write or read -> ACCESS.
    - On that edge, latch addr, wdata and op (op=write if write=1, even when read=1 simultaneously).
    - Load the wait counter with WAIT_CYCLES.
  - Else remain in IDLE.
- ACCESS:
  - busy=1.
  - addr/wdata/read/write changes are ignored; the latched values are used.
  - Counter decrements each cycle.
  - On the edge where counter==0:
    - write op: mem[latched addr] <= latched wdata.
    - read op: rdata <= mem[latched addr].
    - Go to RESP.
  - ACCESS lasts exactly WAIT_CYCLES+1 cycles.
- RESP: ready=1 and busy=1 for exactly one cycle, then IDLE unconditionally.
- Latency: request sampled at edge E0 -> ready high during the cycle following edge E0+WAIT_CYCLES+1.
  - WAIT_CYCLES=0 gives ready in the 2nd cycle after the request edge.
- Request protocol:
  - Requests are sampled only in IDLE.
  - The controller must drop read/write in the ready cycle.
  - A request still high when IDLE is re-entered starts a new access.
- Read-after-write to the same address returns the newly written data, since the accesses are serialised.
- LOAD:
  - busy=1.
  - Each cycle with load_valid=1: mem[ptr] <= load_data; ptr++.
  - Cycles with load_valid=0 are stalls; no write occurs.
  - Exit to IDLE with load_done=1 on the first of:
    - the write to address 2**ADDR_W-1 (the pointer never wraps);
    - load_en=0, sampled at an edge in LOAD. Any load_valid on that same cycle is ignored.
  - read/write are ignored during LOAD.
- load_done stays high until reset or the next entry into LOAD.
- Reset mid-operation:
  - The access is abandoned; an uncommitted write is never performed.
  - No ready pulse occurs.
  - A partial load leaves the bytes already written in memory; load_done=0.

Decomposition:
- Shared package cpu_pkg holds:
  - the ADDR_W/DATA_W defaults and MEM_DEPTH;
  - the mem_unit state enum {IDLE, ACCESS, RESP, LOAD};
  - the WAIT_CYCLES maximum (15).
- Sub-module mem_array: single-port storage, synchronous write, registered read.
- mem_unit contains the FSM, counters, latches and the port mux (LOAD vs ACCESS) into mem_array.

Test Plan:
- WAIT_CYCLES=2: write addr=0x10 data=0xA5, then read 0x10 -> ready exactly 3 cycles after each request edge; rdata=0xA5; busy high 4 cycles per access.
- read and write both high, addr=0x20, wdata=0x3C -> treated as a write; mem[0x20]=0x3C; rdata unchanged from its prior value.
- Change addr from 0x10 to 0x11 during ACCESS on a read -> rdata returns mem[0x10].
- Boot load of bytes 0x01..0x05 with a 2-cycle load_valid gap, then load_en dropped -> mem[0..4]=01..05; load_done=1; subsequent reads of 0..4 match; read asserted during LOAD is not serviced.
- Full load of 256 bytes with load_en held -> exit after the write to 0xFF; load_done=1; the pointer never wraps (mem[0]=first byte).
- Reset asserted mid-ACCESS of a write of 0x77 to 0x30, where mem[0x30] was 0x11 -> mem[0x30] stays 0x11; no ready pulse; all outputs at their reset values the next cycle.
